// File: rtl/fifobram_buffer_if.sv
// rtl/fifobram_buffer_if.sv - write/read/status bundle between a fifobram source and its user
interface fifobram_buffer_if #(
  parameter int WIDTH      = 32,
  parameter int LOG2_DEPTH = 5
);
  logic                  i_we;
  logic [LOG2_DEPTH-1:0] i_waddr;
  logic [WIDTH-1:0]      i_wdata;
  logic [1:0]            i_wfifobram;
  logic                  i_re;
  logic [LOG2_DEPTH-1:0] i_raddr;
  logic [1:0]            i_rfifobram;
  logic                  i_flush;
  logic [WIDTH-1:0]      o_rdata;
  logic                  o_rvalid;
  logic                  o_almostfull;
  logic                  o_empty;
  logic [LOG2_DEPTH:0]   o_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_we, i_waddr, i_wdata, i_wfifobram, i_re, i_raddr, i_rfifobram, i_flush,
    input  o_rdata, o_rvalid, o_almostfull, o_empty, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_we, i_waddr, i_wdata, i_wfifobram, i_re, i_raddr, i_rfifobram, i_flush,
    output o_rdata, o_rvalid, o_almostfull, o_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifobram_buffer.sv
// rtl/fifobram_buffer.sv - dual-store buffer: random-access BRAM plus circular FIFO,
// pipelined read return, almost-full slack, flush and sticky error flags.
module fifobram_buffer #(
  parameter int WIDTH            = 32,
  parameter int LOG2_DEPTH       = 5,
  parameter int READ_LATENCY     = 1,
  parameter int ALMOSTFULL_SLACK = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  fifobram_buffer_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CW    = LOG2_DEPTH + 1;
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF_LEVEL = CW'(DEPTH - ALMOSTFULL_SLACK);

  logic [WIDTH-1:0]        r_bram [DEPTH];
  logic [WIDTH-1:0]        r_fifo [DEPTH];
  logic [LOG2_DEPTH-1:0]   r_wptr;
  logic [LOG2_DEPTH-1:0]   r_rptr;
  logic [CW-1:0]           r_count;
  logic                    r_overflow;
  logic                    r_underflow;
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [WIDTH-1:0]        r_pipe_dat [READ_LATENCY];

  logic             w_push_req;
  logic             w_pop_req;
  logic             w_bram_rd;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_rd_issue;
  logic [WIDTH-1:0] w_rd_data;

  assign w_push_req = bus.i_we && bus.i_wfifobram[1];
  assign w_pop_req  = bus.i_re && (bus.i_rfifobram == 2'b10);
  assign w_bram_rd  = bus.i_re && (bus.i_rfifobram == 2'b01);
  assign w_pop_ok   = w_pop_req && (r_count != '0) && !bus.i_flush;
  // A same-cycle pop frees the head slot, so a full FIFO still takes the push.
  assign w_push_ok  = w_push_req && ((r_count < C_DEPTH) || w_pop_ok) && !bus.i_flush;
  assign w_rd_issue = w_bram_rd || w_pop_ok;
  assign w_rd_data  = w_bram_rd ? r_bram[bus.i_raddr] : r_fifo[r_rptr];

  // Storage arrays carry no reset; the read mux above samples them before the write lands.
  always_ff @(posedge i_clk) begin
    if (bus.i_we && bus.i_wfifobram[0]) begin
      r_bram[bus.i_waddr] <= bus.i_wdata;
    end
    if (w_push_ok) begin
      r_fifo[r_wptr] <= bus.i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.i_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - 1'b1;
      end
      if (w_push_req && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
      if (w_pop_req && (r_count == '0)) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Return pipeline: the last stage's data only moves on a valid, so rdata holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_pipe_dat[k] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_rd_issue;
      if (w_rd_issue) begin
        r_pipe_dat[0] <= w_rd_data;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        if (r_pipe_vld[k-1]) begin
          r_pipe_dat[k] <= r_pipe_dat[k-1];
        end
      end
    end
  end

  assign bus.o_rdata      = r_pipe_dat[READ_LATENCY-1];
  assign bus.o_rvalid     = r_pipe_vld[READ_LATENCY-1];
  assign bus.o_count      = r_count;
  assign bus.o_empty      = (r_count == '0);
  assign bus.o_almostfull = (r_count >= C_AF_LEVEL);
  assign bus.o_overflow   = r_overflow;
  assign bus.o_underflow  = r_underflow;
endmodule
